// File: rtl/cyber_pkg.sv
// Shared types and widths for the cyber_player automated opponent.
package cyber_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        COOLD
    } cp_state_t;

    localparam int CP_WIDTH = 10;
    localparam int CP_CNT_W = 16;

endpackage

// File: rtl/tick_div.sv
// Free-running clock divider producing a one-cycle strobe every DIV cycles.
// The strobe is registered: it is high in the cycle after the counter shows DIV-1.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_cnt;
    logic         wrap;

    assign wrap = (div_cnt == W'(DIV - 1));

    // Count 0..DIV-1 and register the wrap point as the strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= wrap;
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cyber_player.sv
// Automated reaction-game opponent: steps the LFSR, compares each fresh value
// against a threshold and issues a fixed-length press followed by a cooldown.
// Optional press statistics are built when CYBER_PLAYER_STATS_EN is defined;
// otherwise press_count is a constant zero.
module cyber_player
    import cyber_pkg::*;
#(
    parameter int WIDTH           = CP_WIDTH,
    parameter int TICK_DIV        = 4,
    parameter int PRESS_CYCLES    = 3,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                active,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [WIDTH-1:0]    rnd,
    output logic                lfsr_en,
    output logic                press,
    output logic [CP_CNT_W-1:0] press_count
);

    localparam int HC_MAX = (PRESS_CYCLES > COOLDOWN_CYCLES) ? PRESS_CYCLES : COOLDOWN_CYCLES;
    localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;

    cp_state_t       state, state_nxt;
    logic [HC_W-1:0] hc, hc_nxt;
    logic            sample_v;
    logic            hit;

    tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (lfsr_en)
    );

    // rnd already holds the post-step value in the cycle after the strobe.
    assign hit = sample_v && (rnd < threshold);

    // Next-state logic; dropping active overrides every FSM transition.
    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        if (!active) begin
            state_nxt = IDLE;
            hc_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_nxt = PRESS;
                        hc_nxt    = '0;
                    end
                end
                PRESS: begin
                    if (hc == HC_W'(PRESS_CYCLES - 1)) begin
                        state_nxt = COOLD;
                        hc_nxt    = '0;
                    end else begin
                        hc_nxt = hc + 1'b1;
                    end
                end
                COOLD: begin
                    if (hc == HC_W'(COOLDOWN_CYCLES - 1)) begin
                        state_nxt = IDLE;
                        hc_nxt    = '0;
                    end else begin
                        hc_nxt = hc + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hc_nxt    = '0;
                end
            endcase
        end
    end

    // State, hold counter, sample-valid delay and the registered press output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            hc       <= '0;
            sample_v <= 1'b0;
            press    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hc       <= hc_nxt;
            sample_v <= lfsr_en;
            press    <= (state_nxt == PRESS);
        end
    end

`ifdef CYBER_PLAYER_STATS_EN
    logic [CP_CNT_W-1:0] cnt;

    // Count IDLE->PRESS transitions, holding at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if ((state == IDLE) && (state_nxt == PRESS) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign press_count = cnt;
`else
    assign press_count = '0;
`endif

endmodule

// File: tb/tb_cyber_player.sv
// Bench for cyber_player: directed scenarios plus randomized traffic, checked
// every cycle against a timeline model of the player (press windows and
// re-arm times computed from the sample cycle, not from an FSM copy).
module tb_cyber_player;

    localparam int W  = 10;
    localparam int TD = 4;
    localparam int PC = 3;
    localparam int CC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          active = 1'b0;
    logic [W-1:0]  threshold = '0;
    logic [W-1:0]  rnd = 10'h001;
    logic          lfsr_en;
    logic          press;
    logic [15:0]   press_count;

    int total = 0;
    int bad   = 0;

    // Model state, all in absolute cycle numbers.
    longint n           = 0;
    longint rel_base    = 0;
    longint idle_from   = 0;
    longint press_start = 1;
    longint press_end   = 0;
    int     mcnt        = 0;
    bit     mvalid      = 0;

    // Stimulus modes for rnd: 0 fixed, 1 random, 2 alternate 0FF/100.
    int           rnd_mode = 0;
    logic [W-1:0] rnd_fix  = 10'h001;
    int           step_idx = 0;

    cyber_player #(
        .WIDTH           (W),
        .TICK_DIV        (TD),
        .PRESS_CYCLES    (PC),
        .COOLDOWN_CYCLES (CC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .threshold   (threshold),
        .rnd         (rnd),
        .lfsr_en     (lfsr_en),
        .press       (press),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_en(longint c);
        longint r;
        r = c - rel_base;
        return (r > 0) && (r % TD == 0);
    endfunction

    function automatic bit m_sample(longint c);
        longint r;
        r = c - rel_base;
        return (r > 1) && ((r - 1) % TD == 0);
    endfunction

    function automatic logic [W-1:0] rand_rnd();
        logic [W-1:0] v;
        do v = W'($urandom); while (v == '1);
        return v;
    endfunction

    task automatic tick();
        bit     exp_en;
        bit     exp_press;
        logic [15:0] exp_cnt;
        bit     en_now;
        @(negedge clk);
        if (mvalid) begin
            exp_en    = m_en(n);
            exp_press = (n >= press_start) && (n <= press_end);
`ifdef CYBER_PLAYER_STATS_EN
            exp_cnt = 16'(mcnt);
`else
            exp_cnt = 16'h0000;
`endif
            total++;
            assert (lfsr_en === exp_en) else begin
                bad++;
                $error("FAIL lfsr_en cyc=%0d observed=%b expected=%b", n - rel_base, lfsr_en, exp_en);
            end
            total++;
            assert (press === exp_press) else begin
                bad++;
                $error("FAIL press cyc=%0d observed=%b expected=%b", n - rel_base, press, exp_press);
            end
            total++;
            assert (press_count === exp_cnt) else begin
                bad++;
                $error("FAIL press_count cyc=%0d observed=%h expected=%h", n - rel_base, press_count, exp_cnt);
            end
        end
        @(posedge clk);
        en_now = m_en(n);
        if (!reset) begin
            mvalid      = 1;
            rel_base    = n + 1;
            idle_from   = 0;
            press_start = 1;
            press_end   = 0;
            mcnt        = 0;
            en_now      = 0;
        end else if (!active) begin
            if (press_end > n) press_end = n;
            if (idle_from > n + 1) idle_from = n + 1;
        end else if (m_sample(n) && (n >= idle_from) && (rnd < threshold)) begin
            press_start = n + 1;
            press_end   = n + PC;
            idle_from   = n + 1 + PC + CC;
            if (mcnt < 16'hFFFF) mcnt++;
        end
        n++;
        #1;
        if (en_now) begin
            step_idx++;
            case (rnd_mode)
                0:       rnd = rnd_fix;
                1:       rnd = rand_rnd();
                default: rnd = step_idx[0] ? 10'h0FF : 10'h100;
            endcase
        end
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Leaves the bench in cycle 0 after release (reset high, nothing sampled yet).
    task automatic do_reset(int len);
        reset = 1'b0;
        run(len);
        reset = 1'b1;
        step_idx = 0;
        if (rnd_mode == 0) rnd = rnd_fix;
    endtask

    initial begin
        // 1: threshold zero never presses
        active = 1'b1; threshold = '0; rnd_mode = 1; rnd = rand_rnd();
        do_reset(3);
        run(1000);

        // 2: always-hit, period of PC+CC+... cadence
        rnd_mode = 0; rnd_fix = 10'h001; threshold = 10'h3FF;
        do_reset(2);
        run(40);

        // 3: boundary compare at threshold 0x100
        rnd_mode = 2; threshold = 10'h100; rnd = 10'h100;
        do_reset(2);
        run(60);

        // 4: active dropped in second press cycle
        rnd_mode = 0; rnd_fix = 10'h001; threshold = 10'h3FF;
        do_reset(2);
        run(7);
        active = 1'b0;
        run(14);
        active = 1'b1;
        run(24);

        // 5: reset pulsed mid-press
        do_reset(2);
        run(7);
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        run(24);

        // 6: randomized traffic with occasional threshold/active/reset changes
        rnd_mode = 1;
        do_reset(2);
        for (int blk = 0; blk < 40; blk++) begin
            case ($urandom_range(0, 3))
                0:       threshold = '0;
                1:       threshold = '1;
                default: threshold = W'($urandom);
            endcase
            for (int i = 0; i < 50; i++) begin
                active = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b0;
                    run(1);
                    reset = 1'b1;
                end
                tick();
            end
        end
        active = 1'b1;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
